irq_controller: RTL
===================

Name: irq_controller

Overview:
- Memory-mapped interrupt aggregator sitting downstream of the system peripherals (TimerCounter Intr, miniUART IntRx_N/IntTx_N, GPIO Intr).
- Synchronises the low-active sources, latches them into pending bits under per-source enable and level/edge mode, and drives a single low-active interrupt request toward the RV32I core.
- Exposes the same CS_N/RD_N/WR_N/Addr/DataIn/DataOut slave interface as the other peripherals. A new Addr_Decoder chip select maps onto it.

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..16); source i has id i, and lower id means higher priority.
- SYNC_STAGES, 2, flip-flop stages in each source synchroniser (>=2).

Ports:
- clk  input  1  system clock; driven with ~clk0 like the other peripherals.
- reset  input  1  asynchronous active-high reset.
- CS_N  input  1  chip select, active-low.
- RD_N  input  1  read strobe, active-low.
- WR_N  input  1  write strobe, active-low.
- Addr  input  12  byte address; only Addr[4:2] are decoded.
- DataIn  input  32  write data.
- DataOut  output  32  read data.
- Src_N  input  NUM_SRC  raw interrupt sources, active-low, asynchronous to clk.
- Intr_N  output  1  interrupt request to the CPU, active-low, registered.

Behaviour:
- Reset: every synchroniser flop =1 (inactive); PENDING=0; ENABLE=0; MODE=0; Intr_N=1; DataOut=0.
- Synchroniser: act[i] = ~(last sync stage of Src_N[i]). Edge detect uses act_d (act delayed one cycle); rise[i] = act[i] & ~act_d[i].
- Register map, word offset Addr[4:2]:
  - 0 STATUS (RO) = act.
  - 1 PENDING (R/W1C).
  - 2 ENABLE (RW).
  - 3 MODE (RW); 1 = edge, 0 = level.
  - 4 CLAIM (RO) = {valid, 26'b0, id[4:0]}.
  - 5 SWSET (WO); writing 1 to a bit sets that pending bit.
  - 6, 7 reserved; read 0, writes ignored.
- Register width: bits above NUM_SRC-1 read 0, and writes to them are ignored.
- Write: occurs on the clk edge while CS_N=0 and WR_N=0.
- Read: DataOut is combinational. DataOut = selected register when CS_N=0 and RD_N=0, else 0. Reads have no side effects, including reads of CLAIM.
- Level mode (MODE[i]=0): pending[i] <= act[i] | swset[i]. A W1C write has no effect while act[i]=1.
- Edge mode (MODE[i]=1): pending[i] <= (pending[i] & ~w1c[i]) | rise[i] | swset[i]. If a set and a clear arrive in the same cycle, set wins.
- Masking: pending bits latch regardless of ENABLE. ENABLE only masks CLAIM and Intr_N.
- CLAIM: valid = |(PENDING & ENABLE). id = lowest index among the enabled pending bits; id=0 when valid=0.
- Intr_N: Intr_N <= ~|(PENDING & ENABLE), registered one cycle after PENDING.
- Latency: Src_N falls before edge 0 → act at edge SYNC_STAGES-1 → pending at edge SYNC_STAGES → Intr_N low at edge SYNC_STAGES+1 (edge 3 with defaults).
- Glitches: a pulse shorter than one clk period may be missed; this is permitted.
- Mode change mid-operation: the current pending value is kept. After the change, the new mode's update rule applies.
- Reset mid-operation: all state returns to reset values immediately. After release, a level source that is still asserted re-pends after SYNC_STAGES+1 edges. An edge source re-pends only if act_d was reset and the source is still active, i.e. reset counts as an inactive history.

Optional Feature:
- Macro IRQC_GLOBAL_MASK_EN.
- When defined: word offset 6 = GCTRL (RW, bit0 = global enable, reset 0). Intr_N <= ~(GCTRL[0] & |(PENDING & ENABLE)). CLAIM is unaffected by GCTRL.
- When undefined: offset 6 is reserved (reads 0), and Intr_N follows the base rule.

Test Plan:
- Reset release, read all registers → STATUS/PENDING/ENABLE/MODE/CLAIM all 0x00000000; Intr_N=1.
- ENABLE=0x1, MODE=0, hold Src_N[0]=0 → PENDING=0x1 at edge 2, Intr_N=0 at edge 3, CLAIM=0x80000000. Write W1C 0x1 while held → PENDING stays 0x1. Release Src_N[0] → PENDING=0 two cycles later, Intr_N=1 one cycle after that.
- MODE=0xF, ENABLE=0xF, pulse Src_N[2] low for 3 cycles → PENDING=0x4 and stays set after release; CLAIM=0x80000002. W1C 0x4 → PENDING=0, Intr_N=1 next cycle.
- Edge mode: Src_N[1] and Src_N[3] asserted together → PENDING=0xA, CLAIM id=1. W1C 0x2 in the same cycle as a new rise on source 1 → PENDING remains 0xA (set wins).
- ENABLE=0, write SWSET=0x8 → PENDING=0x8, CLAIM=0, Intr_N=1. Write ENABLE=0x8 → CLAIM=0x80000003, Intr_N=0 one cycle later.
- With IRQC_GLOBAL_MASK_EN: PENDING&ENABLE≠0 and GCTRL=0 → Intr_N=1. Write GCTRL=1 → Intr_N=0 next cycle. Without the macro: a read at offset 6 returns 0.

Source files
------------

// File: rtl/irq_controller.sv
// Interrupt aggregator: synchronises low-active sources, latches pending bits
// (level/edge, per-source enable) and drives a registered low-active Intr_N.
// Optional macro IRQC_GLOBAL_MASK_EN adds a global-enable register GCTRL at word 6.
module irq_controller #(
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               CS_N,
    input  logic               RD_N,
    input  logic               WR_N,
    input  logic [11:0]        Addr,
    input  logic [31:0]        DataIn,
    output logic [31:0]        DataOut,
    input  logic [NUM_SRC-1:0] Src_N,
    output logic               Intr_N
);

    localparam logic [2:0] A_STATUS  = 3'd0;
    localparam logic [2:0] A_PENDING = 3'd1;
    localparam logic [2:0] A_ENABLE  = 3'd2;
    localparam logic [2:0] A_MODE    = 3'd3;
    localparam logic [2:0] A_CLAIM   = 3'd4;
    localparam logic [2:0] A_SWSET   = 3'd5;
`ifdef IRQC_GLOBAL_MASK_EN
    localparam logic [2:0] A_GCTRL   = 3'd6;
`endif

    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
    logic [NUM_SRC-1:0] act;
    logic [NUM_SRC-1:0] act_d_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pend_q;
    logic [NUM_SRC-1:0] pend_d;
    logic [NUM_SRC-1:0] en_q;
    logic [NUM_SRC-1:0] mode_q;
    logic [NUM_SRC-1:0] wdata;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] swset;
    logic [NUM_SRC-1:0] pe;
    logic [2:0]         word;
    logic               wr_en;
    logic               claim_valid;
    logic [4:0]         claim_id;
    logic               intr_n_q;
    logic               intr_n_d;
    logic               gate;
    logic               unused_bits;

    assign unused_bits = ^{Addr, DataIn};

    // Stage 0 samples the raw pins; the last stage feeds the rest of the logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else if (SYNC_STAGES > 1) begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], Src_N};
        end else begin
            sync_q <= Src_N;
        end
    end

    assign act   = ~sync_q[SYNC_STAGES-1];
    assign rise  = act & ~act_d_q;

    assign word  = Addr[4:2];
    assign wr_en = ~CS_N & ~WR_N;
    assign wdata = DataIn[NUM_SRC-1:0];
    assign w1c   = (wr_en && word == A_PENDING) ? wdata : '0;
    assign swset = (wr_en && word == A_SWSET)   ? wdata : '0;

    // Edge mode: a set in the same cycle as a clear wins.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pend
        assign pend_d[gi] = mode_q[gi] ? ((pend_q[gi] & ~w1c[gi]) | rise[gi] | swset[gi])
                                       : (act[gi] | swset[gi]);
    end

    assign pe          = pend_q & en_q;
    assign claim_valid = |pe;

    always_comb begin
        claim_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pe[i]) begin
                claim_id = 5'(i);
            end
        end
    end

`ifdef IRQC_GLOBAL_MASK_EN
    logic gctrl_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gctrl_q <= 1'b0;
        end else if (wr_en && word == A_GCTRL) begin
            gctrl_q <= DataIn[0];
        end
    end

    assign gate = gctrl_q;
`else
    assign gate = 1'b1;
`endif

    assign intr_n_d = ~(gate & claim_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_d_q  <= '0;
            pend_q   <= '0;
            en_q     <= '0;
            mode_q   <= '0;
            intr_n_q <= 1'b1;
        end else begin
            act_d_q  <= act;
            pend_q   <= pend_d;
            intr_n_q <= intr_n_d;
            if (wr_en && word == A_ENABLE) begin
                en_q <= wdata;
            end
            if (wr_en && word == A_MODE) begin
                mode_q <= wdata;
            end
        end
    end

    assign Intr_N = intr_n_q;

    // Reads are side-effect free, CLAIM included.
    always_comb begin
        DataOut = '0;
        if (!CS_N && !RD_N) begin
            case (word)
                A_STATUS:  DataOut[NUM_SRC-1:0] = act;
                A_PENDING: DataOut[NUM_SRC-1:0] = pend_q;
                A_ENABLE:  DataOut[NUM_SRC-1:0] = en_q;
                A_MODE:    DataOut[NUM_SRC-1:0] = mode_q;
                A_CLAIM:   DataOut = {claim_valid, 26'b0, claim_id};
`ifdef IRQC_GLOBAL_MASK_EN
                A_GCTRL:   DataOut[0] = gctrl_q;
`endif
                default:   DataOut = '0;
            endcase
        end
    end

endmodule
